// File: rtl/regfile_arbiter_if.sv
// -----------------------------------------------------------------------------
// regfile_arbiter_if
// Bundles the two requester command/response channels and the register-file
// control pins that sit around regfile_arbiter.
//   Requester A/B : ReqX, WrX, AddrX, WDataX  -> arbiter
//                   GntX, RValidX, RDataX     <- arbiter
//   Register file : RF_WrEn, RF_RdEn, RF_Address, RF_WrData <- arbiter
//                   RF_RdData                               -> arbiter
// modport slave  : the arbiter's view.
// modport master : the environment's view (requesters + register file).
// -----------------------------------------------------------------------------
interface regfile_arbiter_if #(
    parameter int unsigned addrs_wdth = 3,
    parameter int unsigned mem_wdth   = 16
);
    // Requester A
    logic                  ReqA;
    logic                  WrA;
    logic [addrs_wdth-1:0] AddrA;
    logic [mem_wdth-1:0]   WDataA;
    logic                  GntA;
    logic                  RValidA;
    logic [mem_wdth-1:0]   RDataA;

    // Requester B
    logic                  ReqB;
    logic                  WrB;
    logic [addrs_wdth-1:0] AddrB;
    logic [mem_wdth-1:0]   WDataB;
    logic                  GntB;
    logic                  RValidB;
    logic [mem_wdth-1:0]   RDataB;

    // Register file pins
    logic                  RF_WrEn;
    logic                  RF_RdEn;
    logic [addrs_wdth-1:0] RF_Address;
    logic [mem_wdth-1:0]   RF_WrData;
    logic [mem_wdth-1:0]   RF_RdData;

    modport slave (
        input  ReqA, WrA, AddrA, WDataA,
        input  ReqB, WrB, AddrB, WDataB,
        input  RF_RdData,
        output GntA, RValidA, RDataA,
        output GntB, RValidB, RDataB,
        output RF_WrEn, RF_RdEn, RF_Address, RF_WrData
    );

    modport master (
        output ReqA, WrA, AddrA, WDataA,
        output ReqB, WrB, AddrB, WDataB,
        output RF_RdData,
        input  GntA, RValidA, RDataA,
        input  GntB, RValidB, RDataB,
        input  RF_WrEn, RF_RdEn, RF_Address, RF_WrData
    );
endinterface

// File: rtl/regfile_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_arbiter
// Round-robin arbiter/sequencer letting two requesters (A, B) share a
// single-port register file with a registered read port.
// Ports:
//   CLK  : clock, rising edge.
//   RST  : asynchronous active-high reset.
//   bus  : regfile_arbiter_if.slave - requester handshakes and RF pins.
// A command is accepted only in IDLE: the winner gets a one-cycle Gnt and the
// matching one-cycle RF strobe. Writes finish in WR; reads pass RD (RF
// samples RdEn) and RWAIT (RF output is valid) before returning data.
// All outputs are registered.
// -----------------------------------------------------------------------------
module regfile_arbiter #(
    parameter int unsigned addrs_wdth = 3,
    parameter int unsigned mem_wdth   = 16
) (
    input  logic             CLK,
    input  logic             RST,
    regfile_arbiter_if.slave bus
);
    localparam int unsigned AW = addrs_wdth;
    localparam int unsigned DW = mem_wdth;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WR    = 2'd1,
        RD    = 2'd2,
        RWAIT = 2'd3
    } state_e;

    typedef struct packed {
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } cmd_t;

    state_e state_q, state_d;

    logic          gnt_a_q,    gnt_a_d;
    logic          gnt_b_q,    gnt_b_d;
    logic          rvalid_a_q, rvalid_a_d;
    logic          rvalid_b_q, rvalid_b_d;
    logic [DW-1:0] rdata_a_q,  rdata_a_d;
    logic [DW-1:0] rdata_b_q,  rdata_b_d;
    logic          rf_wr_en_q, rf_wr_en_d;
    logic          rf_rd_en_q, rf_rd_en_d;
    logic [AW-1:0] rf_addr_q,  rf_addr_d;
    logic [DW-1:0] rf_wdata_q, rf_wdata_d;
    logic          last_b_q,   last_b_d;   // 1: B was served last
    logic          owner_b_q,  owner_b_d;  // 1: current transaction is B's

    logic win_a_c;
    logic win_b_c;
    cmd_t win_cmd_c;

    // Arbitration: a lone requester always wins; on a tie the side not served
    // last wins.
    always_comb begin : arb_comb
        win_a_c   = bus.ReqA && (!bus.ReqB || last_b_q);
        win_b_c   = bus.ReqB && !win_a_c;
        win_cmd_c = win_b_c ? cmd_t'{bus.WrB, bus.AddrB, bus.WDataB}
                            : cmd_t'{bus.WrA, bus.AddrA, bus.WDataA};
    end

    // State register
    always_ff @(posedge CLK or posedge RST) begin : state_reg
        if (RST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; requests are only looked at in IDLE
    always_comb begin : next_state_comb
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (win_a_c || win_b_c) begin
                    state_d = win_cmd_c.wr ? WR : RD;
                end
            end
            WR:      state_d = IDLE;
            RD:      state_d = RWAIT;
            RWAIT:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output/datapath next values; strobes default low, data registers hold
    always_comb begin : output_comb
        gnt_a_d    = 1'b0;
        gnt_b_d    = 1'b0;
        rvalid_a_d = 1'b0;
        rvalid_b_d = 1'b0;
        rf_wr_en_d = 1'b0;
        rf_rd_en_d = 1'b0;
        rdata_a_d  = rdata_a_q;
        rdata_b_d  = rdata_b_q;
        rf_addr_d  = rf_addr_q;
        rf_wdata_d = rf_wdata_q;
        last_b_d   = last_b_q;
        owner_b_d  = owner_b_q;
        case (state_q)
            IDLE: begin
                if (win_a_c || win_b_c) begin
                    gnt_a_d    = win_a_c;
                    gnt_b_d    = win_b_c;
                    rf_addr_d  = win_cmd_c.addr;
                    rf_wdata_d = win_cmd_c.wdata;
                    rf_wr_en_d = win_cmd_c.wr;
                    rf_rd_en_d = !win_cmd_c.wr;
                    last_b_d   = win_b_c;
                    owner_b_d  = win_b_c;
                end
            end
            RWAIT: begin
                // RF_RdData was registered by the RF at the RD->RWAIT edge
                if (owner_b_q) begin
                    rdata_b_d  = bus.RF_RdData;
                    rvalid_b_d = 1'b1;
                end else begin
                    rdata_a_d  = bus.RF_RdData;
                    rvalid_a_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Output and datapath registers; pointer resets to "B served last"
    always_ff @(posedge CLK or posedge RST) begin : out_reg
        if (RST) begin
            gnt_a_q    <= 1'b0;
            gnt_b_q    <= 1'b0;
            rvalid_a_q <= 1'b0;
            rvalid_b_q <= 1'b0;
            rdata_a_q  <= '0;
            rdata_b_q  <= '0;
            rf_wr_en_q <= 1'b0;
            rf_rd_en_q <= 1'b0;
            rf_addr_q  <= '0;
            rf_wdata_q <= '0;
            last_b_q   <= 1'b1;
            owner_b_q  <= 1'b0;
        end else begin
            gnt_a_q    <= gnt_a_d;
            gnt_b_q    <= gnt_b_d;
            rvalid_a_q <= rvalid_a_d;
            rvalid_b_q <= rvalid_b_d;
            rdata_a_q  <= rdata_a_d;
            rdata_b_q  <= rdata_b_d;
            rf_wr_en_q <= rf_wr_en_d;
            rf_rd_en_q <= rf_rd_en_d;
            rf_addr_q  <= rf_addr_d;
            rf_wdata_q <= rf_wdata_d;
            last_b_q   <= last_b_d;
            owner_b_q  <= owner_b_d;
        end
    end

    assign bus.GntA       = gnt_a_q;
    assign bus.GntB       = gnt_b_q;
    assign bus.RValidA    = rvalid_a_q;
    assign bus.RValidB    = rvalid_b_q;
    assign bus.RDataA     = rdata_a_q;
    assign bus.RDataB     = rdata_b_q;
    assign bus.RF_WrEn    = rf_wr_en_q;
    assign bus.RF_RdEn    = rf_rd_en_q;
    assign bus.RF_Address = rf_addr_q;
    assign bus.RF_WrData  = rf_wdata_q;

endmodule

// File: tb/tb_regfile_arbiter.sv
// -----------------------------------------------------------------------------
// tb_regfile_arbiter
// Directed bench for regfile_arbiter with a behavioural single-port register
// file (registered read data). Inputs change and outputs are sampled on the
// falling edge; cyc counts rising edges.
// -----------------------------------------------------------------------------
module tb_regfile_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail  = 0;

    regfile_arbiter_if #(.addrs_wdth(3), .mem_wdth(16)) bus ();

    regfile_arbiter #(.addrs_wdth(3), .mem_wdth(16)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Register file model
    logic [15:0] mem [8] = '{default: 16'h0};
    logic [15:0] rf_rddata = 16'h0;
    always @(posedge clk) begin
        if (bus.RF_WrEn) mem[bus.RF_Address] <= bus.RF_WrData;
        if (bus.RF_RdEn) rf_rddata <= mem[bus.RF_Address];
    end
    assign bus.RF_RdData = rf_rddata;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed time %0t required < 500000", $time);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ctrl"}, 32'({bus.GntA, bus.GntB, bus.RValidA, bus.RValidB,
                                 bus.RF_WrEn, bus.RF_RdEn}), 32'd0);
        chk({tag, "_rdata"}, {bus.RDataA, bus.RDataB}, 32'd0);
        chk({tag, "_rf"}, 32'({bus.RF_Address, bus.RF_WrData}), 32'd0);
    endtask

    // Raise a request, wait (bounded) for its grant, drop the request and
    // check the RF strobes launched with the grant.
    task automatic issue(input bit side, input bit wr, input logic [2:0] addr,
                         input logic [15:0] wd, input string tag, output int g);
        g = -1;
        if (!side) begin
            bus.ReqA = 1'b1; bus.WrA = wr; bus.AddrA = addr; bus.WDataA = wd;
        end else begin
            bus.ReqB = 1'b1; bus.WrB = wr; bus.AddrB = addr; bus.WDataB = wd;
        end
        for (int i = 0; i < 20 && g < 0; i++) begin
            @(negedge clk);
            if (side ? bus.GntB : bus.GntA) g = cyc;
        end
        if (!side) bus.ReqA = 1'b0;
        else       bus.ReqB = 1'b0;
        chk({tag, "_gnt"}, 32'(g >= 0), 32'd1);
        chk({tag, "_gnt_other"}, 32'(side ? bus.GntA : bus.GntB), 32'd0);
        chk({tag, "_strobe"}, 32'({bus.RF_WrEn, bus.RF_RdEn, bus.RF_Address}),
            32'({wr, !wr, addr}));
        if (wr) chk({tag, "_wdata"}, 32'(bus.RF_WrData), 32'(wd));
    endtask

    task automatic wait_rv(input bit side, input string tag, output int v,
                           output logic [15:0] d);
        v = -1;
        d = 16'h0;
        for (int i = 0; i < 10 && v < 0; i++) begin
            @(negedge clk);
            if (side ? bus.RValidB : bus.RValidA) begin
                v = cyc;
                d = side ? bus.RDataB : bus.RDataA;
            end
        end
        chk({tag, "_rv_other"}, 32'(side ? bus.RValidA : bus.RValidB), 32'd0);
    endtask

    task automatic do_read(input bit side, input logic [2:0] addr,
                           input logic [15:0] exp, input string tag, output int g);
        int          v;
        logic [15:0] d;
        issue(side, 1'b0, addr, 16'h0, tag, g);
        wait_rv(side, tag, v, d);
        chk({tag, "_lat"}, 32'(v - g), 32'd2);
        chk({tag, "_data"}, 32'(d), 32'(exp));
    endtask

    initial begin
        int          g0, g1, s, ng;
        int          gc [4];
        logic [3:0]  seq;

        bus.ReqA = 1'b0; bus.WrA = 1'b0; bus.AddrA = 3'd0; bus.WDataA = 16'h0;
        bus.ReqB = 1'b0; bus.WrB = 1'b0; bus.AddrB = 3'd0; bus.WDataB = 16'h0;

        // Reset with random inputs
        for (int i = 0; i < 2; i++) begin
            bus.ReqA = 1'($urandom); bus.WrA = 1'($urandom);
            bus.AddrA = 3'($urandom); bus.WDataA = 16'($urandom);
            bus.ReqB = 1'($urandom); bus.WrB = 1'($urandom);
            bus.AddrB = 3'($urandom); bus.WDataB = 16'($urandom);
            @(negedge clk);
            chk_all_zero("reset");
        end
        bus.ReqA = 1'b0; bus.ReqB = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_gnt", 32'({bus.GntA, bus.GntB}), 32'd0);

        // A: write 127 to 0, then read back
        issue(1'b0, 1'b1, 3'd0, 16'd127, "a_wr0", g0);
        do_read(1'b0, 3'd0, 16'd127, "a_rd0", g1);
        chk("a_wr_rd_spacing", 32'(g1 - g0), 32'd2);

        // Cross-requester traffic
        issue(1'b1, 1'b1, 3'd7, 16'd6120, "b_wr7", g0);
        issue(1'b0, 1'b1, 3'd5, 16'd716, "a_wr5", g0);
        do_read(1'b1, 3'd5, 16'd716, "b_rd5", g0);
        chk("a_rdata_undisturbed", 32'(bus.RDataA), 32'd127);
        do_read(1'b0, 3'd7, 16'd6120, "a_rd7", g0);
        chk("b_rdata_undisturbed", 32'(bus.RDataB), 32'd716);

        // Make B the last served so A should win the coming tie
        do_read(1'b1, 3'd7, 16'd6120, "b_rd7", g0);

        // Contention: both write address 2 continuously
        bus.ReqA = 1'b1; bus.WrA = 1'b1; bus.AddrA = 3'd2; bus.WDataA = 16'd623;
        bus.ReqB = 1'b1; bus.WrB = 1'b1; bus.AddrB = 3'd2; bus.WDataB = 16'd1;
        ng  = 0;
        seq = 4'h0;
        for (int i = 0; i < 20 && ng < 4; i++) begin
            @(negedge clk);
            if (bus.GntA || bus.GntB) begin
                chk("cont_one_gnt", 32'(bus.GntA & bus.GntB), 32'd0);
                seq[ng] = bus.GntB;
                gc[ng]  = cyc;
                ng++;
            end
        end
        bus.ReqA = 1'b0; bus.ReqB = 1'b0;
        chk("cont_count", 32'(ng), 32'd4);
        chk("cont_order", 32'(seq), 32'b1010);
        chk("cont_spacing", 32'(gc[3] - gc[0]), 32'd6);
        do_read(1'b0, 3'd2, 16'd1, "cont_rd2", g0);

        // Reset during RWAIT discards the read
        issue(1'b0, 1'b0, 3'd0, 16'h0, "rst_rd", g0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk_all_zero("mid_rst");
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("mid_rst_no_rv", 32'(bus.RValidA), 32'd0);
        end
        chk("mid_rst_rdata", 32'(bus.RDataA), 32'd0);

        // Pointer is back to "B last": A wins the tie, B follows right after
        bus.ReqB = 1'b1; bus.WrB = 1'b0; bus.AddrB = 3'd0;
        s = cyc;
        do_read(1'b0, 3'd2, 16'd1, "rr_a", g0);
        chk("rr_a_first", 32'(g0 - s), 32'd1);
        do_read(1'b1, 3'd0, 16'd127, "rr_b", g1);
        chk("rr_b_pending", 32'(g1 - g0), 32'd3);

        // Back-to-back reads from B
        do_read(1'b1, 3'd0, 16'd127, "b2b_0", g0);
        do_read(1'b1, 3'd2, 16'd1, "b2b_1", g1);
        chk("b2b_sp1", 32'(g1 - g0), 32'd3);
        do_read(1'b1, 3'd5, 16'd716, "b2b_2", g0);
        chk("b2b_sp2", 32'(g0 - g1), 32'd3);
        do_read(1'b1, 3'd7, 16'd6120, "b2b_3", g1);
        chk("b2b_sp3", 32'(g1 - g0), 32'd3);

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/regfile_arbiter.md
# regfile_arbiter

Two-port round-robin arbiter and sequencer for the single-port register file (`Register_file`: one shared `Address`, `WrEn`/`RdEn`, registered `RdData`). It lets two independent requesters, A and B, issue read or write commands through a request/grant handshake. It drives the register-file control pins with one-cycle strobes and returns read data to the requester that issued the read, with a valid pulse. It sits directly in front of the register file; neither requester touches the register file pins.

## Interface

**Parameters**
- `addrs_wdth`, default 3: address width.
- `mem_wdth`, default 16: data width.

**Ports**

Clock and reset are fixed: one clock, `CLK`; `RST` is an asynchronous, active-high reset.

- `CLK`  in  1  system clock; all state changes on the rising edge.
- `RST`  in  1  asynchronous, active-high reset.
- `ReqA`, `ReqB`  in  1  command request from requester A / B.
- `WrA`, `WrB`  in  1  command type: 1 = write, 0 = read.
- `AddrA`, `AddrB`  in  `addrs_wdth`  command address.
- `WDataA`, `WDataB`  in  `mem_wdth`  write data; ignored for reads.
- `GntA`, `GntB`  out  1  grant pulse; the command has been accepted.
- `RValidA`, `RValidB`  out  1  read-data-valid pulse.
- `RDataA`, `RDataB`  out  `mem_wdth`  returned read data.
- `RF_WrEn`, `RF_RdEn`  out  1  register file write / read strobe.
- `RF_Address`  out  `addrs_wdth`  register file address.
- `RF_WrData`  out  `mem_wdth`  register file write data.
- `RF_RdData`  in  `mem_wdth`  register file read data, registered by the register file (valid one edge after `RF_RdEn` is sampled).

## Operation

**General**
- All outputs are registered.
- **Reset values:** every output is 0; state = `IDLE`; round-robin pointer = "B served last", so A wins the first tie.

**States**
- `IDLE`: no transaction in progress.
  - If neither request is high: stay in `IDLE`.
  - If exactly one request is high: that requester wins.
  - If both are high: the requester not served last wins.
  - On the deciding edge:
    - Pulse the winner's `Gnt` for 1 cycle.
    - Load `RF_Address` and `RF_WrData` from the winner.
    - Set `RF_WrEn` (write) or `RF_RdEn` (read) for 1 cycle.
    - Update the round-robin pointer.
    - Record the owner.
    - Move to `WR` or `RD`.
- `WR`: clear `RF_WrEn`, then go to `IDLE`. The register file stores the data on this edge.
- `RD`: clear `RF_RdEn`, then go to `RWAIT`. The register file captures its `RdData` on this edge.
- `RWAIT`: copy `RF_RdData` into the owner's `RData`, pulse the owner's `RValid` for 1 cycle, then go to `IDLE`.

**Handshake**
- A requester holds `Req`, `Wr`, `Addr` and `WData` stable until it samples its `Gnt` high, and drops `Req` in that same cycle unless it has a new command.
- `Req` is not sampled outside `IDLE`, so a requester cannot be granted twice for one command.

**Hold and data behaviour**
- `RF_Address` and `RF_WrData` hold their last values while idle.
- Each `RDataX` holds its value until that requester's next read completes.
- The non-owner's `RData` and `RValid` are never disturbed.
- Data passes through unmodified; there is no arithmetic or width conversion. Address wrap-around is the register file's concern and the arbiter passes all `2^addrs_wdth` addresses.

## Timing

**Latency** (E0 = the `IDLE` edge at which the request is sampled)
- Write: `Gnt` and `RF_WrEn` are high in cycle E0→E1; the register file writes at E1; `IDLE` is reached at E1. Minimum spacing between writes is 2 cycles.
- Read: `RF_RdEn` is high in cycle E0→E1; `RValid` and `RData` are driven at E2 and valid in cycle E2→E3. Minimum spacing between reads is 3 cycles.

**Boundary conditions**
- **Simultaneous requests:** exactly one grant; the loser stays pending and is granted at the next `IDLE` edge.
- **Continuous requests from both sides:** grants strictly alternate A, B, A, B.
- **Lone requester:** always wins, regardless of the pointer.
- **`RST` mid-transaction:** asynchronous return to `IDLE`, all outputs forced to 0, any pending read discarded (no `RValid`), pointer reset.
- A read immediately following a write to the same address returns the new data.

## Test plan

- **Reset:** assert `RST` for 2 cycles with random inputs → all outputs 0 during reset; first `Gnt` occurs no earlier than the first edge after release.
- **Write then read back, A:** write 127 to address 0, then read address 0 → `GntA` pulse on each; `RValidA` exactly 2 cycles after the read's grant edge; `RDataA` = 127; `RValidB` stays 0.
- **Cross-requester:** B writes 6120 to address 7; A writes 716 to address 5; B reads address 5; A reads address 7 → `RDataB` = 716, `RDataA` = 6120.
- **Contention:** `ReqA` and `ReqB` both held high with writes (A: address 2, data 623; B: address 2, data 1) → first grant to A, then B, alternating; final read of address 2 returns 1.
- **Reset mid-read:** A reads address 0; pulse `RST` in the `RWAIT` cycle → no `RValidA`, `RDataA` = 0; the next request is granted normally.
- **Back-to-back:** single requester B issuing 4 consecutive reads → grants exactly 3 cycles apart; each `RValidB` carries the correct data.
